// File: rtl/cu51_pkg.sv
// Shared constants for the 8051-style control unit: opcodes, ALU encodings,
// machine-cycle slot numbers and the two machine-cycle states.
package cu51_pkg;

  typedef logic [3:0] slot_t;

  localparam slot_t T_FETCH = 4'd5;
  localparam slot_t T_OPND  = 4'd11;
  localparam slot_t T_LAST  = 4'd11;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_MOV_A_IMM = 8'h74;
  localparam logic [7:0] OP_ANL_A_DIR = 8'h55;
  localparam logic [7:0] OP_SJMP      = 8'h80;
  localparam logic [7:0] OP_SETB_BIT  = 8'hD2;
  localparam logic [7:0] OP_MOVX_A_R0 = 8'hE2;
  localparam logic [7:0] OP_MOVX_A_R1 = 8'hE3;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_AND  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_ADD  = 4'd3
  } alu_op_e;

  typedef enum logic {
    CYC_M1 = 1'b0,
    CYC_M2 = 1'b1
  } cycle_e;

  // Opcodes that carry a second code byte fetched late in M1.
  function automatic logic is_two_byte(input logic [7:0] op);
    return op inside {OP_MOV_A_IMM, OP_ANL_A_DIR, OP_SJMP, OP_SETB_BIT};
  endfunction

endpackage

// File: rtl/mcu51_cu_timing.sv
// Twelve-slot machine-cycle counter with the derived Phase and ALE strobes.
module mcu51_cu_timing
  import cu51_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  output slot_t t,
  output logic  Phase,
  output logic  ALE
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)            t <= '0;
    else if (t == T_LAST) t <= '0;
    else                  t <= t + 4'd1;
  end

  assign Phase = ~reset & t[0];
  assign ALE   = ~reset & (t inside {4'd1, 4'd2, 4'd7, 4'd8});

endmodule

// File: rtl/mcu51_cu.sv
// 8051 control unit: slot/cycle sequencing and opcode decode into datapath strobes.
// Build option: define CU_MOVX_EN to execute MOVX A,@Ri (E2/E3); otherwise they run as NOP.
module mcu51_cu
  import cu51_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [7:0] direct,
  output logic       Phase,
  output logic       ALE,
  output logic       PSEN,
  output logic       RD,
  output logic       WR,
  output logic [2:0] PC_CON,
  output logic       CODE_CS,
  output logic       IR_en,
  output logic       Bb,
  output logic [7:0] position,
  output logic       Rn_ext,
  output logic       Ri_at,
  output logic [1:0] XDATA_CON,
  output logic [1:0] DATA_CON,
  output logic       rel_en,
  output logic       direct_en,
  output logic       bit_en,
  output logic [1:0] R_Vt1_CON,
  output logic [1:0] R_Vt2_CON,
  output logic [1:0] A_CON,
  output logic [1:0] B_CON,
  output logic [1:0] PSW_CON,
  output logic [3:0] ALU_CON,
  output logic [3:0] P0_CON,
  output logic [3:0] P1_CON,
  output logic [3:0] P2_CON,
  output logic [3:0] P3_CON
);

`ifdef CU_MOVX_EN
  localparam bit MOVX_EN = 1'b1;
`else
  localparam bit MOVX_EN = 1'b0;
`endif

  slot_t      t;
  cycle_e     m, m_next;
  logic [7:0] ir_hold;
  logic [7:0] op;
  logic       movx_op;
  logic       two_cycle;
  logic       unused_direct;

  assign unused_direct = ^direct[7:3];

  mcu51_cu_timing u_timing (
    .clk   (clk),
    .reset (reset),
    .t     (t),
    .Phase (Phase),
    .ALE   (ALE)
  );

  always_ff @(posedge clk) begin
    if (reset) m <= CYC_M1;
    else       m <= m_next;
  end

  // The opcode is tracked from the late half of M1 so M2 ignores later IR changes.
  always_ff @(posedge clk) begin
    if (reset)                      ir_hold <= OP_NOP;
    else if (m == CYC_M1 && t >= 4'd6) ir_hold <= IR;
  end

  assign op        = (m == CYC_M2) ? ir_hold : IR;
  assign movx_op   = MOVX_EN && (op inside {OP_MOVX_A_R0, OP_MOVX_A_R1});
  assign two_cycle = (op inside {OP_ANL_A_DIR, OP_SJMP, OP_SETB_BIT}) || movx_op;

  always_comb begin
    m_next = m;
    if (t == T_OPND) m_next = (m == CYC_M1 && two_cycle) ? CYC_M2 : CYC_M1;
  end

  // NOTE: every output gets a default first, so no path through the decode can infer a latch.
  always_comb begin
    PSEN      = 1'b1;
    RD        = 1'b1;
    WR        = 1'b1;
    PC_CON    = 3'b000;
    CODE_CS   = 1'b0;
    IR_en     = 1'b0;
    Bb        = 1'b0;
    position  = 8'h00;
    Rn_ext    = 1'b0;
    Ri_at     = 1'b0;
    XDATA_CON = 2'b00;
    DATA_CON  = 2'b00;
    rel_en    = 1'b0;
    direct_en = 1'b0;
    bit_en    = 1'b0;
    R_Vt1_CON = 2'b00;
    R_Vt2_CON = 2'b00;
    A_CON     = 2'b00;
    B_CON     = 2'b00;
    PSW_CON   = 2'b00;
    ALU_CON   = ALU_PASS;
    P0_CON    = 4'b0000;
    P1_CON    = 4'b0000;
    P2_CON    = 4'b0000;
    P3_CON    = 4'b0000;

    if (!reset) begin
      Rn_ext = (op[7:5] == 3'b111) && op[3];
      Ri_at  = (op[7:5] == 3'b111) && ((op[3:1] == 3'b011) || movx_op);

      if (m == CYC_M1) begin
        if (t inside {[4'd3:T_FETCH]}) begin
          CODE_CS = 1'b1;
          PSEN    = 1'b0;
        end
        if (t == T_FETCH) begin
          IR_en  = 1'b1;
          PC_CON = 3'b100;
        end
        if (is_two_byte(op) && t >= 4'd9) begin
          CODE_CS = 1'b1;
          PSEN    = 1'b0;
          if (t == T_OPND) PC_CON = 3'b100;
        end
        if (t == T_OPND) begin
          case (op)
            OP_MOV_A_IMM: A_CON     = 2'b10;
            OP_ANL_A_DIR: direct_en = 1'b1;
            OP_SJMP:      rel_en    = 1'b1;
            OP_SETB_BIT:  bit_en    = 1'b1;
            default: ;
          endcase
        end
      end else begin
        case (op)
          OP_ANL_A_DIR: begin
            if (t <= 4'd3) DATA_CON = 2'b11;
            if (t == 4'd3) R_Vt1_CON = 2'b10;
            if (t inside {4'd4, 4'd5}) ALU_CON = ALU_AND;
            if (t == 4'd5) A_CON = 2'b10;
          end
          OP_SJMP: if (t == 4'd5) PC_CON = 3'b111;
          OP_SETB_BIT: begin
            if (t <= 4'd5) begin
              Bb       = 1'b1;
              position = 8'd1 << direct[2:0];
            end
            if (t inside {4'd4, 4'd5}) DATA_CON = 2'b01;
          end
          default: begin
            if (movx_op) begin
              if (t <= 4'd2) P0_CON = 4'b1010;
              if (t inside {[4'd3:4'd9]}) begin
                RD        = 1'b0;
                XDATA_CON = 2'b11;
              end
              if (t == 4'd9) begin
                P0_CON = 4'b0001;
                A_CON  = 2'b10;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcu51_cu.sv
// Scoreboard bench for mcu51_cu: the driver queues one expected output word per
// clock, a negedge monitor pops and compares it against the live outputs.
module tb_mcu51_cu;

`ifdef CU_MOVX_EN
  localparam bit MOVX_ON = 1'b1;
`else
  localparam bit MOVX_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] IR = 8'h00;
  logic [7:0] direct = 8'h00;

  logic       Phase, ALE, PSEN, RD, WR, CODE_CS, IR_en, Bb, Rn_ext, Ri_at;
  logic       rel_en, direct_en, bit_en;
  logic [2:0] PC_CON;
  logic [7:0] position;
  logic [1:0] XDATA_CON, DATA_CON, R_Vt1_CON, R_Vt2_CON, A_CON, B_CON, PSW_CON;
  logic [3:0] ALU_CON, P0_CON, P1_CON, P2_CON, P3_CON;

  mcu51_cu dut (
    .clk(clk), .reset(reset), .IR(IR), .direct(direct),
    .Phase(Phase), .ALE(ALE), .PSEN(PSEN), .RD(RD), .WR(WR),
    .PC_CON(PC_CON), .CODE_CS(CODE_CS), .IR_en(IR_en), .Bb(Bb), .position(position),
    .Rn_ext(Rn_ext), .Ri_at(Ri_at), .XDATA_CON(XDATA_CON), .DATA_CON(DATA_CON),
    .rel_en(rel_en), .direct_en(direct_en), .bit_en(bit_en),
    .R_Vt1_CON(R_Vt1_CON), .R_Vt2_CON(R_Vt2_CON), .A_CON(A_CON), .B_CON(B_CON),
    .PSW_CON(PSW_CON), .ALU_CON(ALU_CON),
    .P0_CON(P0_CON), .P1_CON(P1_CON), .P2_CON(P2_CON), .P3_CON(P3_CON)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       phase, ale, psen, rd, wr;
    logic [2:0] pc;
    logic       code_cs, ir_en, bb;
    logic [7:0] position;
    logic       rn_ext, ri_at;
    logic [1:0] xdata, data;
    logic       rel_en, direct_en, bit_en;
    logic [1:0] rvt1, rvt2, a, b, psw;
    logic [3:0] alu, p0, p1, p2, p3;
  } outs_t;

  outs_t exp_q[$];
  string tag_q[$];
  outs_t mon_got;
  int    tests = 0;
  int    failures = 0;

  task automatic check(input string name, input outs_t got, input outs_t exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Hand-written timing chart of the expected strobes for one slot.
  function automatic outs_t model(input bit rst, input logic [7:0] ir_now,
                                  input logic [7:0] op, input logic [7:0] dir,
                                  input bit m2, input int t);
    outs_t e;
    logic [7:0] ir_use;
    e = '0;
    e.psen = 1'b1;
    e.rd   = 1'b1;
    e.wr   = 1'b1;
    if (rst) return e;
    e.phase = (t % 2 == 1);
    e.ale   = (t == 1 || t == 2 || t == 7 || t == 8);
    ir_use  = m2 ? op : ir_now;
    e.rn_ext = (ir_use[7:4] == 4'hE || ir_use[7:4] == 4'hF) && ir_use[3];
    e.ri_at  = (ir_use[7:4] == 4'hE || ir_use[7:4] == 4'hF) &&
               (ir_use[3:1] == 3'b011 || (MOVX_ON && (ir_use == 8'hE2 || ir_use == 8'hE3)));
    if (!m2) begin
      if (t >= 3 && t <= 5) begin e.code_cs = 1'b1; e.psen = 1'b0; end
      if (t == 5) begin e.ir_en = 1'b1; e.pc = 3'b100; end
      if ((op == 8'h74 || op == 8'h55 || op == 8'h80 || op == 8'hD2) && t >= 9) begin
        e.code_cs = 1'b1;
        e.psen    = 1'b0;
        if (t == 11) e.pc = 3'b100;
      end
      if (t == 11 && op == 8'h74) e.a = 2'b10;
      if (t == 11 && op == 8'h55) e.direct_en = 1'b1;
      if (t == 11 && op == 8'h80) e.rel_en = 1'b1;
      if (t == 11 && op == 8'hD2) e.bit_en = 1'b1;
    end else if (op == 8'h55) begin
      if (t <= 3) e.data = 2'b11;
      if (t == 3) e.rvt1 = 2'b10;
      if (t == 4 || t == 5) e.alu = 4'd1;
      if (t == 5) e.a = 2'b10;
    end else if (op == 8'h80) begin
      if (t == 5) e.pc = 3'b111;
    end else if (op == 8'hD2) begin
      if (t <= 5) begin e.bb = 1'b1; e.position = 8'd1 << dir[2:0]; end
      if (t == 4 || t == 5) e.data = 2'b01;
    end else if (MOVX_ON && (op == 8'hE2 || op == 8'hE3)) begin
      if (t <= 2) e.p0 = 4'b1010;
      if (t >= 3 && t <= 9) begin e.rd = 1'b0; e.xdata = 2'b11; end
      if (t == 9) begin e.p0 = 4'b0001; e.a = 2'b10; end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_got = {Phase, ALE, PSEN, RD, WR, PC_CON, CODE_CS, IR_en, Bb, position,
                 Rn_ext, Ri_at, XDATA_CON, DATA_CON, rel_en, direct_en, bit_en,
                 R_Vt1_CON, R_Vt2_CON, A_CON, B_CON, PSW_CON, ALU_CON,
                 P0_CON, P1_CON, P2_CON, P3_CON};
      check(tag_q.pop_front(), mon_got, exp_q.pop_front());
    end
  end

  task automatic step(input outs_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // One instruction: IR reaches the bus at M1 t=6 and is scrambled during M2.
  task automatic run_instr(input logic [7:0] op, input logic [7:0] dir, input int abort_k);
    int n;
    bit two;
    two = (op == 8'h55 || op == 8'h80 || op == 8'hD2 ||
           (MOVX_ON && (op == 8'hE2 || op == 8'hE3)));
    n = two ? 24 : 12;
    direct = dir;
    for (int k = 0; k < n; k++) begin
      bit m2;
      int t;
      m2 = (k >= 12);
      t  = k % 12;
      if (k == abort_k) begin
        reset = 1'b1;
        for (int r = 0; r < 3; r++)
          step(model(1'b1, IR, op, dir, 1'b0, 0), $sformatf("abort_rst op%02h r%0d", op, r));
        reset = 1'b0;
        return;
      end
      if (m2) IR = 8'hFB;
      else if (t >= 6) IR = op;
      step(model(1'b0, IR, op, dir, m2, t),
           $sformatf("op%02h M%0d t%0d", op, m2 ? 2 : 1, t));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) step(model(1'b1, IR, 8'h00, 8'h00, 1'b0, 0), $sformatf("reset c%0d", i));
    reset = 1'b0;

    run_instr(8'h00, 8'h00, -1);
    run_instr(8'h74, 8'h00, -1);
    run_instr(8'h55, 8'h30, -1);
    run_instr(8'h80, 8'h12, -1);
    run_instr(8'hD2, 8'h2B, -1);
    run_instr(8'hE3, 8'h00, -1);
    run_instr(8'hE2, 8'h00, -1);
    run_instr(8'h13, 8'h00, -1);
    run_instr(8'h55, 8'h30, 16);
    run_instr(8'h00, 8'h00, -1);
    run_instr(8'hD2, 8'h07, -1);
    run_instr(8'hD2, 8'h00, -1);
    run_instr(8'hA5, 8'h00, -1);
    run_instr(8'h00, 8'h00, -1);

    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: queue depth %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
